fetch_ctrl: RTL and testbench

- Control end of the fetch interface. Drives the fetch stage's Init/Branch_abs/Target/Halt inputs and consumes its 16-bit PC.
- Captures the word returned by the synchronous instruction ROM (1-cycle read latency), decodes jump and halt, and discards the wrong-path slot after a jump.
- Presents retired instructions, tagged with their PC, to decode, and counts them.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_decode.sv | 20 ++
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch control slice.
// Holds the FSM state enum, instruction-format defaults and jump test.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    HALTED
  } state_t;

  localparam int INSTR_W_DEF = 9;
  localparam logic [INSTR_W_DEF-1:0] HALT_OPC_DEF = 9'h0FF;

  // MSB of a w-bit instruction word marks an absolute jump.
  function automatic logic is_jump(
    input logic [31:0] instr,
    input int          w
  );
    return |(instr & (32'd1 << (w - 1)));
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Classifies the ROM word into jump / halt / normal and extracts Target.
// Ports: instr in; jump, halt, target out (all combinational).
module fetch_decode
  import fetch_pkg::*;
#(
  parameter int                 INSTR_W  = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] HALT_OPC = HALT_OPC_DEF
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               jump,
  output logic               halt,
  output logic [7:0]         target
);

  // Halt wins if an override makes the encodings overlap.
  assign halt   = (instr == HALT_OPC);
  assign jump   = !halt && is_jump(32'(instr), INSTR_W);
  assign target = instr[7:0];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch control: drives Init/Branch_abs/Target/Halt, retires ROM words.
// Ports: CLK, RESET_n, Start, PC, Instr in; fetch ctrl, retire, count out.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                 INSTR_W  = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] HALT_OPC = HALT_OPC_DEF,
  parameter int                 CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               RESET_n,
  input  logic               Start,
  input  logic [15:0]        PC,
  input  logic [INSTR_W-1:0] Instr,
  output logic               Init,
  output logic               Branch_abs,
  output logic [7:0]         Target,
  output logic               Halt,
  output logic               Instr_valid,
  output logic [INSTR_W-1:0] Instr_out,
  output logic [15:0]        Instr_PC,
  output logic               Done,
  output logic [CNT_W-1:0]   Retired_cnt
);

  state_t      state;
  state_t      state_nx;
  logic [15:0] pc_q;
  logic        dec_jump;
  logic        dec_halt;
  logic [7:0]  dec_tgt;

  fetch_decode #(
    .INSTR_W  (INSTR_W),
    .HALT_OPC (HALT_OPC)
  ) u_dec (
    .instr  (Instr),
    .jump   (dec_jump),
    .halt   (dec_halt),
    .target (dec_tgt)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nx;
      pc_q  <= PC;
    end
  end

  always_comb begin
    state_nx    = state;
    Init        = 1'b0;
    Branch_abs  = 1'b0;
    Target      = '0;
    Halt        = 1'b0;
    Instr_valid = 1'b0;
    Done        = 1'b0;
    unique case (state)
      IDLE: begin
        Init = 1'b1;
        if (Start) state_nx = FILL;
      end
      FILL: state_nx = RUN;
      RUN: begin
        Instr_valid = 1'b1;
        if (dec_halt) begin
          Halt     = 1'b1;
          state_nx = HALTED;
        end else if (dec_jump) begin
          Branch_abs = 1'b1;
          Target     = dec_tgt;
          state_nx   = FLUSH;
        end
      end
      // Wrong-path word from PC+1 is dropped undecoded.
      FLUSH: state_nx = RUN;
      HALTED: begin
        Halt = 1'b1;
        Done = 1'b1;
        if (Start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Instr_out = Instr_valid ? Instr : '0;
  assign Instr_PC  = pc_q;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      Retired_cnt <= '0;
    end else if (state == IDLE && Start) begin
      Retired_cnt <= '0;
    end else if (Instr_valid && Retired_cnt != '1) begin
      Retired_cnt <= Retired_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a fetch-stage and sync-ROM model.
// Second instance (CNT_W=4) runs NOPs forever to exercise saturation.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] pc;
  logic [8:0]  instr;
  logic        init;
  logic        br;
  logic [7:0]  tgt;
  logic        halt;
  logic        vld;
  logic [8:0]  iout;
  logic [15:0] ipc;
  logic        done;
  logic [15:0] cnt;

  logic [15:0] pc2;
  logic [8:0]  instr2;
  logic        init2;
  logic        br2;
  logic [7:0]  tgt2;
  logic        halt2;
  logic        vld2;
  logic [8:0]  iout2;
  logic [15:0] ipc2;
  logic        done2;
  logic [3:0]  cnt2;

  logic [8:0]  rom [0:255];

  int checks;
  int errors;

  fetch_ctrl dut (
    .CLK         (clk),
    .RESET_n     (rst_n),
    .Start       (start),
    .PC          (pc),
    .Instr       (instr),
    .Init        (init),
    .Branch_abs  (br),
    .Target      (tgt),
    .Halt        (halt),
    .Instr_valid (vld),
    .Instr_out   (iout),
    .Instr_PC    (ipc),
    .Done        (done),
    .Retired_cnt (cnt)
  );

  fetch_ctrl #(.CNT_W(4)) dut2 (
    .CLK         (clk),
    .RESET_n     (rst_n),
    .Start       (start),
    .PC          (pc2),
    .Instr       (instr2),
    .Init        (init2),
    .Branch_abs  (br2),
    .Target      (tgt2),
    .Halt        (halt2),
    .Instr_valid (vld2),
    .Instr_out   (iout2),
    .Instr_PC    (ipc2),
    .Done        (done2),
    .Retired_cnt (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr2 = '0;

  // Fetch stage + 1-cycle ROM for the main instance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      instr <= '0;
    end else begin
      instr <= rom[pc[7:0]];
      if (init)      pc <= '0;
      else if (br)   pc <= {8'h00, tgt};
      else if (!halt) pc <= pc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc2 <= '0;
    else if (init2)  pc2 <= '0;
    else if (br2)    pc2 <= {8'h00, tgt2};
    else if (!halt2) pc2 <= pc2 + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
  endtask

  task automatic restart();
    start = 1'b1;
    tick();
    chk("restart_idle_init", {31'd0, init}, 1);
    chk("restart_idle_done", {31'd0, done}, 0);
    tick();
    start = 1'b0;
    chk("restart_fill_init", {31'd0, init}, 0);
    chk("restart_fill_cnt", {16'd0, cnt}, 0);
    chk("restart_fill_vld", {31'd0, vld}, 0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    rom_clear();
    rom[4] = 9'h0FF;
    #22;
    chk("rst_init", {31'd0, init}, 1);
    chk("rst_br", {31'd0, br}, 0);
    chk("rst_tgt", {24'd0, tgt}, 0);
    chk("rst_halt", {31'd0, halt}, 0);
    chk("rst_vld", {31'd0, vld}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_cnt", {16'd0, cnt}, 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_init", {31'd0, init}, 1);

    // Straight line: NOPs at 0..3, halt at 4.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fill_init", {31'd0, init}, 0);
    chk("fill_vld", {31'd0, vld}, 0);
    tick();
    chk("run0_vld", {31'd0, vld}, 1);
    chk("run0_pc", {16'd0, ipc}, 0);
    chk("run0_cnt", {16'd0, cnt}, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("line_vld", {31'd0, vld}, 1);
      chk("line_pc", {16'd0, ipc}, i);
      chk("line_cnt", {16'd0, cnt}, i);
    end
    tick();
    chk("halt_pc", {16'd0, ipc}, 4);
    chk("halt_sig", {31'd0, halt}, 1);
    chk("halt_iout", {23'd0, iout}, 32'h0FF);
    chk("halt_dut2_cnt", {28'd0, cnt2}, 4);
    tick();
    chk("halted_done", {31'd0, done}, 1);
    chk("halted_vld", {31'd0, vld}, 0);
    chk("halted_cnt", {16'd0, cnt}, 5);
    chk("halted_fpc", {16'd0, pc}, 5);
    tick();
    chk("halted_fpc_hold", {16'd0, pc}, 5);
    chk("halted_cnt_hold", {16'd0, cnt}, 5);

    // Jump 2 -> 0x10 with a jump in the shadow at 3.
    rom_clear();
    rom[2]  = 9'h110;
    rom[3]  = 9'h120;
    rom[16] = 9'h0FF;
    restart();
    chk("j_pc0", {16'd0, ipc}, 0);
    tick();
    chk("j_pc1", {16'd0, ipc}, 1);
    tick();
    chk("j_pc2", {16'd0, ipc}, 2);
    chk("j_br", {31'd0, br}, 1);
    chk("j_tgt", {24'd0, tgt}, 32'h10);
    chk("j_iout", {23'd0, iout}, 32'h110);
    tick();
    chk("flush_vld", {31'd0, vld}, 0);
    chk("flush_br", {31'd0, br}, 0);
    chk("flush_tgt", {24'd0, tgt}, 0);
    chk("flush_iout", {23'd0, iout}, 0);
    chk("flush_fpc", {16'd0, pc}, 32'h10);
    tick();
    chk("j_tpc", {16'd0, ipc}, 32'h10);
    chk("j_tvld", {31'd0, vld}, 1);
    chk("j_thalt", {31'd0, halt}, 1);
    tick();
    chk("j_done", {31'd0, done}, 1);
    chk("j_cnt", {16'd0, cnt}, 4);
    chk("j_fpc", {16'd0, pc}, 32'h11);

    // Jump 2 -> 0x08, shadow jump at 3, then mid-run reset.
    rom_clear();
    rom[2] = 9'h108;
    rom[3] = 9'h120;
    restart();
    tick();
    tick();
    chk("s_br", {31'd0, br}, 1);
    chk("s_tgt", {24'd0, tgt}, 8);
    tick();
    chk("s_flush_br", {31'd0, br}, 0);
    chk("s_flush_vld", {31'd0, vld}, 0);
    tick();
    chk("s_pc8", {16'd0, ipc}, 8);
    chk("s_vld8", {31'd0, vld}, 1);
    chk("s_br8", {31'd0, br}, 0);
    tick();
    chk("s_pc9", {16'd0, ipc}, 9);
    chk("s_cnt", {16'd0, cnt}, 4);
    chk("sat_cnt", {28'd0, cnt2}, 32'hF);
    tick();
    chk("sat_cnt_hold", {28'd0, cnt2}, 32'hF);

    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_init", {31'd0, init}, 1);
    chk("mid_rst_vld", {31'd0, vld}, 0);
    chk("mid_rst_cnt", {16'd0, cnt}, 0);
    chk("mid_rst_ipc", {16'd0, ipc}, 0);
    chk("mid_rst_cnt2", {28'd0, cnt2}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_vld", {31'd0, vld}, 0);
    chk("post_rst_init", {31'd0, init}, 1);
    chk("post_rst_cnt", {16'd0, cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
